// File: rtl/tick_counter_ctrl_pkg.sv
// Shared types and defaults for the tick counter controller.
// State encodings match the board-level encodings used by the status decoding.
package tick_counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned TICK_DIV_DEF = 50_000_000;
  localparam int unsigned DB_CYC_DEF   = 500_000;
  localparam int unsigned MAX_VAL_DEF  = 15;

  // Preset values above the terminal count are saturated so Data stays decodable.
  function automatic logic [3:0] clamp_val(input logic [3:0] v, input logic [3:0] max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/tick_counter_ctrl_if.sv
// Board-side controls and status of the tick counter.
// master = key/switch panel side, slave = counter.
interface tick_counter_ctrl_if;
  logic       start_btn;
  logic       clear_btn;
  logic       load_btn;
  logic       dir_sw;
  logic [3:0] load_val;
  logic [3:0] Data;
  logic       running;
  logic       done;
  logic       tc_pulse;

  modport master (
    output start_btn, clear_btn, load_btn, dir_sw, load_val,
    input  Data, running, done, tc_pulse
  );

  modport slave (
    input  start_btn, clear_btn, load_btn, dir_sw, load_val,
    output Data, running, done, tc_pulse
  );
endinterface

// File: rtl/tick_counter_ctrl_btn.sv
// Button conditioner: 2-flop synchroniser, debounce and rising-edge event.
// Event is high for the cycle after the debounced level first goes high.
module btn_conditioner
  import tick_counter_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYC = DB_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic ev
);

  localparam int unsigned CW = $clog2(DB_CYC + 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronised samples that disagree with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_q <= level;
      if (s2 != level) begin
        if (cnt == CW'(DB_CYC - 1)) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign ev = level & ~level_q;

endmodule

// File: rtl/tick_counter_ctrl.sv
// Timed 0..MAX_VAL up/down counter with start/pause, clear and load keys.
// Prescaler, FSM and count register; buttons go through btn_conditioner.
module tick_counter_ctrl
  import tick_counter_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned DB_CYC   = DB_CYC_DEF,
  parameter int unsigned MAX_VAL  = MAX_VAL_DEF,
  parameter int unsigned WRAP     = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  tick_counter_ctrl_if.slave bus
);

  localparam int unsigned      PW      = $clog2(TICK_DIV);
  localparam logic [3:0]       MAXV    = 4'(MAX_VAL);
  localparam logic [PW-1:0]    PLAST   = PW'(TICK_DIV - 1);
  localparam bit               WRAP_EN = (WRAP != 0);

  logic ev_start;
  logic ev_clear;
  logic ev_load;

  btn_conditioner #(.DB_CYC(DB_CYC)) u_start (
    .clk(clk), .rst_n(rst_n), .raw(bus.start_btn), .ev(ev_start)
  );
  btn_conditioner #(.DB_CYC(DB_CYC)) u_clear (
    .clk(clk), .rst_n(rst_n), .raw(bus.clear_btn), .ev(ev_clear)
  );
  btn_conditioner #(.DB_CYC(DB_CYC)) u_load (
    .clk(clk), .rst_n(rst_n), .raw(bus.load_btn), .ev(ev_load)
  );

  logic       dir_s1;
  logic       dir;
  logic [3:0] lv_s1;
  logic [3:0] lv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_s1 <= 1'b0;
      dir    <= 1'b0;
      lv_s1  <= '0;
      lv     <= '0;
    end else begin
      dir_s1 <= bus.dir_sw;
      dir    <= dir_s1;
      lv_s1  <= bus.load_val;
      lv     <= lv_s1;
    end
  end

  state_t        state;
  state_t        state_n;
  logic [3:0]    data_q;
  logic [3:0]    data_n;
  logic          tc_q;
  logic          tc_n;
  logic [PW-1:0] pres;
  logic [PW-1:0] pres_n;

  logic [3:0] term;
  logic [3:0] step_val;
  logic [3:0] wrap_val;
  logic       tick;

  assign term     = dir ? MAXV : 4'd0;
  assign wrap_val = dir ? 4'd0 : MAXV;
  assign step_val = dir ? (data_q + 4'd1) : (data_q - 4'd1);
  assign tick     = (state == ST_RUN) && (pres == PLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      data_q <= '0;
      tc_q   <= 1'b0;
      pres   <= '0;
    end else begin
      state  <= state_n;
      data_q <= data_n;
      tc_q   <= tc_n;
      pres   <= pres_n;
    end
  end

  // Priority chain clear > load > start > tick; a load in RUN falls through
  // so a coincident tick is still honoured.
  always_comb begin
    state_n = state;
    data_n  = data_q;
    tc_n    = 1'b0;
    pres_n  = pres;
    if (state == ST_RUN) begin
      pres_n = tick ? '0 : pres + PW'(1);
    end
    if (ev_clear) begin
      state_n = ST_IDLE;
      data_n  = wrap_val;
      pres_n  = '0;
    end else if (ev_load && (state != ST_RUN)) begin
      data_n = clamp_val(lv, MAXV);
      if (state == ST_DONE) state_n = ST_IDLE;
    end else if (ev_start) begin
      case (state)
        ST_IDLE: begin
          pres_n = '0;
          if (!WRAP_EN && (data_q == term)) begin
            state_n = ST_DONE;
            tc_n    = 1'b1;
          end else begin
            state_n = ST_RUN;
          end
        end
        ST_RUN: begin
          state_n = ST_PAUSE;
          pres_n  = pres;
        end
        ST_PAUSE: state_n = ST_RUN;
        default:  ;
      endcase
    end else if (tick) begin
      if (data_q == term) begin
        tc_n = 1'b1;
        if (WRAP_EN) data_n  = wrap_val;
        else         state_n = ST_DONE;
      end else begin
        data_n = step_val;
        if (!WRAP_EN && (step_val == term)) begin
          state_n = ST_DONE;
          tc_n    = 1'b1;
        end
      end
    end
  end

  assign bus.Data     = data_q;
  assign bus.running  = (state == ST_RUN);
  assign bus.done     = (state == ST_DONE);
  assign bus.tc_pulse = tc_q;

endmodule

// File: tb/tb_tick_counter_ctrl.sv
// Directed bench: three counters (WRAP=0 MAX=15, WRAP=1 MAX=15, WRAP=0 MAX=9)
// with TICK_DIV=4, DB_CYC=2; a button press takes effect on the 5th edge.
module tb_tick_counter_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_cmp;
  int unsigned n_err;

  always #5 clk = ~clk;

  tick_counter_ctrl_if ifa ();
  tick_counter_ctrl_if ifb ();
  tick_counter_ctrl_if ifc ();

  tick_counter_ctrl #(.TICK_DIV(4), .DB_CYC(2), .MAX_VAL(15), .WRAP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  tick_counter_ctrl #(.TICK_DIV(4), .DB_CYC(2), .MAX_VAL(15), .WRAP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );
  tick_counter_ctrl #(.TICK_DIV(4), .DB_CYC(2), .MAX_VAL(9), .WRAP(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // m = {load, clear, start}
  task automatic drive(input int unsigned d, input logic [2:0] m);
    case (d)
      0:       {ifa.load_btn, ifa.clear_btn, ifa.start_btn} = m;
      1:       {ifb.load_btn, ifb.clear_btn, ifb.start_btn} = m;
      default: {ifc.load_btn, ifc.clear_btn, ifc.start_btn} = m;
    endcase
  endtask

  task automatic press(input int unsigned d, input logic [2:0] m);
    drive(d, m);
    step(5);
    drive(d, 3'b000);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int unsigned d, input logic [3:0] dat,
                        input logic run, input logic dn, input logic tc);
    logic [3:0] o_dat;
    logic       o_run, o_dn, o_tc;
    case (d)
      0:       begin o_dat = ifa.Data; o_run = ifa.running; o_dn = ifa.done; o_tc = ifa.tc_pulse; end
      1:       begin o_dat = ifb.Data; o_run = ifb.running; o_dn = ifb.done; o_tc = ifb.tc_pulse; end
      default: begin o_dat = ifc.Data; o_run = ifc.running; o_dn = ifc.done; o_tc = ifc.tc_pulse; end
    endcase
    chk({tag, ".Data"}, 32'(o_dat), 32'(dat));
    chk({tag, ".running"}, 32'(o_run), 32'(run));
    chk({tag, ".done"}, 32'(o_dn), 32'(dn));
    chk({tag, ".tc_pulse"}, 32'(o_tc), 32'(tc));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(0, 3'b000); drive(1, 3'b000); drive(2, 3'b000);
    ifa.dir_sw = 1'b1; ifa.load_val = 4'd0;
    ifb.dir_sw = 1'b0; ifb.load_val = 4'd1;
    ifc.dir_sw = 1'b1; ifc.load_val = 4'd12;
    step(2);
    chk_st("reset_a", 0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(3);

    // up-count from 0, one step per 4 cycles
    press(0, 3'b001);
    chk_st("start_a", 0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(3); chk_st("pre_step", 0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1); chk_st("step1", 0, 4'd1, 1'b1, 1'b0, 1'b0);
    step(4); chk_st("step2", 0, 4'd2, 1'b1, 1'b0, 1'b0);
    step(4); chk_st("step3", 0, 4'd3, 1'b1, 1'b0, 1'b0);

    // pause with 2 prescaler cycles spent, resume needs exactly 2 more
    step(2); press(0, 3'b001);
    chk_st("pause", 0, 4'd4, 1'b0, 1'b0, 1'b0);
    step(20); chk_st("pause_hold", 0, 4'd4, 1'b0, 1'b0, 1'b0);
    press(0, 3'b001);
    chk_st("resume", 0, 4'd4, 1'b1, 1'b0, 1'b0);
    step(1); chk_st("resume_1", 0, 4'd4, 1'b1, 1'b0, 1'b0);
    step(1); chk_st("resume_2", 0, 4'd5, 1'b1, 1'b0, 1'b0);

    // load 13 while paused, run up to terminal 15
    step(6); press(0, 3'b001);
    chk_st("pause2", 0, 4'd7, 1'b0, 1'b0, 1'b0);
    ifa.load_val = 4'd13;
    press(0, 3'b100);
    chk_st("load13", 0, 4'd13, 1'b0, 1'b0, 1'b0);
    press(0, 3'b001);
    chk_st("run13", 0, 4'd13, 1'b1, 1'b0, 1'b0);
    step(2); chk_st("run14", 0, 4'd14, 1'b1, 1'b0, 1'b0);
    step(3); chk_st("hold14", 0, 4'd14, 1'b1, 1'b0, 1'b0);
    step(1); chk_st("term15", 0, 4'd15, 1'b0, 1'b1, 1'b1);
    step(1); chk_st("tc_drop", 0, 4'd15, 1'b0, 1'b1, 1'b0);
    step(8); chk_st("done_hold", 0, 4'd15, 1'b0, 1'b1, 1'b0);
    press(0, 3'b001);
    chk_st("done_start", 0, 4'd15, 1'b0, 1'b1, 1'b0);

    // clear and load together: clear wins
    press(0, 3'b110);
    chk_st("clr_ld", 0, 4'd0, 1'b0, 1'b0, 1'b0);

    // start from IDLE already at terminal goes straight to DONE
    ifa.load_val = 4'd15;
    step(6); press(0, 3'b100);
    chk_st("load15", 0, 4'd15, 1'b0, 1'b0, 1'b0);
    press(0, 3'b001);
    chk_st("idle_term", 0, 4'd15, 1'b0, 1'b1, 1'b1);
    step(1); chk_st("idle_term_1", 0, 4'd15, 1'b0, 1'b1, 1'b0);

    // WRAP=1 down-count: 1 -> 0 -> 15 (tc) -> 14
    press(1, 3'b100);
    chk_st("b_load1", 1, 4'd1, 1'b0, 1'b0, 1'b0);
    press(1, 3'b001);
    chk_st("b_start", 1, 4'd1, 1'b1, 1'b0, 1'b0);
    step(4); chk_st("b_zero", 1, 4'd0, 1'b1, 1'b0, 1'b0);
    step(4); chk_st("b_wrap", 1, 4'd15, 1'b1, 1'b0, 1'b1);
    step(1); chk_st("b_wrap_1", 1, 4'd15, 1'b1, 1'b0, 1'b0);
    step(3); chk_st("b_14", 1, 4'd14, 1'b1, 1'b0, 1'b0);

    // MAX_VAL=9: load saturates, bounces are rejected, clear with dir=0 gives MAX_VAL
    press(2, 3'b100);
    chk_st("c_load12", 2, 4'd9, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      ifc.start_btn = 1'b1; step(1);
      ifc.start_btn = 1'b0; step(1);
    end
    step(8); chk_st("c_bounce", 2, 4'd9, 1'b0, 1'b0, 1'b0);
    ifc.load_val = 4'd3;
    press(2, 3'b100);
    chk_st("c_load3", 2, 4'd3, 1'b0, 1'b0, 1'b0);
    ifc.dir_sw = 1'b0;
    step(3); press(2, 3'b010);
    chk_st("c_clr_dn", 2, 4'd9, 1'b0, 1'b0, 1'b0);

    // asynchronous reset between clock edges
    #3 rst_n = 1'b0;
    #1;
    chk_st("b_async_rst", 1, 4'd0, 1'b0, 1'b0, 1'b0);
    chk_st("a_async_rst", 0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
